// File: rtl/axis_fifo_writer.sv
// AXI-Stream to async-FIFO write-port adapter.
// A 2-entry skid buffer decouples s_axis_tready from the FIFO full flag.
// Packets longer than MAX_PKT_LEN are cut: the last kept beat is marked
// as end-of-packet and the remainder is discarded up to the real tlast.
module axis_fifo_writer #(
  parameter int LOGIC_SIZE  = 8,
  parameter int MAX_PKT_LEN = 256
) (
  input  logic                  i_wclk,
  input  logic                  i_rst_n,
  input  logic [LOGIC_SIZE-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  o_wr,
  output logic [LOGIC_SIZE:0]   o_wdata,
  input  logic                  i_wfull,
  output logic [15:0]           o_pkt_count,
  output logic [15:0]           o_trunc_count,
  output logic                  o_busy
);

  typedef enum logic {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;

  localparam int          WW        = LOGIC_SIZE + 1;
  // Beat index at which the end-of-packet flag is forced.
  localparam logic [15:0] LAST_BCNT = 16'(MAX_PKT_LEN - 1);

  state_t          state_q, state_d;
  logic [WW-1:0]   buf0_q, buf0_d;   // head of the skid buffer
  logic [WW-1:0]   buf1_q, buf1_d;   // second entry
  logic [1:0]      cnt_q, cnt_d;
  logic [15:0]     bcnt_q, bcnt_d;
  logic [15:0]     pkt_q, pkt_d;
  logic [15:0]     trunc_q, trunc_d;
  logic            tready_q, tready_d;

  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            forced_s;
  logic            last_s;
  logic [WW-1:0]   word_s;

  // Next-state logic: buffer push/pop, packet length tracking, counters.
  always_comb begin
    state_d  = state_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    pkt_d    = pkt_q;
    trunc_d  = trunc_q;

    accept_s = s_axis_tvalid && tready_q;
    push_s   = accept_s && (state_q == ST_PASS);
    pop_s    = (cnt_q != 2'd0) && !i_wfull;
    forced_s = (bcnt_q == LAST_BCNT);
    last_s   = s_axis_tlast || forced_s;
    word_s   = {last_s, s_axis_tdata};

    // Skid buffer: the head always sits in buf0, pushes land behind it.
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d = word_s;
        end else begin
          buf1_d = word_s;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = word_s;
        end else begin
          buf0_d = word_s;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    if (push_s) begin
      if (last_s) begin
        bcnt_d = 16'd0;
      end else begin
        bcnt_d = bcnt_q + 16'd1;
      end
    end else begin
      bcnt_d = bcnt_q;
    end

    case (state_q)
      ST_PASS: begin
        if (push_s && forced_s && !s_axis_tlast) begin
          state_d = ST_DROP;
          trunc_d = trunc_q + 16'd1;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_DROP: begin
        if (accept_s && s_axis_tlast) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase

    if (pop_s && buf0_q[LOGIC_SIZE]) begin
      pkt_d = pkt_q + 16'd1;
    end else begin
      pkt_d = pkt_q;
    end

    // Ready is precomputed for the next cycle so it never depends on inputs.
    tready_d = (state_d == ST_DROP) || (cnt_d != 2'd2);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_wclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_PASS;
      buf0_q   <= {WW{1'b0}};
      buf1_q   <= {WW{1'b0}};
      cnt_q    <= 2'd0;
      bcnt_q   <= 16'd0;
      pkt_q    <= 16'd0;
      trunc_q  <= 16'd0;
      tready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      pkt_q    <= pkt_d;
      trunc_q  <= trunc_d;
      tready_q <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign o_wr          = pop_s;
  assign o_wdata       = (cnt_q != 2'd0) ? buf0_q : {WW{1'b0}};
  assign o_pkt_count   = pkt_q;
  assign o_trunc_count = trunc_q;
  assign o_busy        = (cnt_q != 2'd0) || (bcnt_q != 16'd0) || (state_q == ST_DROP);

endmodule

// File: tb/tb_axis_fifo_writer.sv
// Self-checking bench for axis_fifo_writer with a queue-based reference model.
module tb_axis_fifo_writer;

  localparam int LS = 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LS-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic          wr;
  logic [LS:0]   wdata;
  logic          wfull = 1'b0;
  logic [15:0]   pkt_cnt;
  logic [15:0]   trunc_cnt;
  logic          busy;

  axis_fifo_writer #(.LOGIC_SIZE(LS), .MAX_PKT_LEN(ML)) dut (
    .i_wclk(clk), .i_rst_n(rst_n),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .o_wr(wr), .o_wdata(wdata), .i_wfull(wfull),
    .o_pkt_count(pkt_cnt), .o_trunc_count(trunc_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: words waiting to be written, packet progress, counters.
  logic [LS:0] exp_q[$];
  logic [LS:0] obs_q[$];
  int          obs_cyc[$];
  int          bcnt_m = 0;
  bit          drop_m = 1'b0;
  int          pushes_m = 0;
  logic [15:0] pkt_m = 16'd0;
  logic [15:0] trunc_m = 16'd0;

  task automatic model_accept(input logic [LS-1:0] d, input logic l);
    bit forced;
    bit lastf;
    if (drop_m) begin
      if (l) drop_m = 1'b0;
    end else begin
      forced = (bcnt_m == ML - 1);
      lastf  = l || forced;
      exp_q.push_back({lastf, d});
      pushes_m++;
      if (lastf) bcnt_m = 0;
      else bcnt_m++;
      if (forced && !l) begin
        trunc_m = trunc_m + 16'd1;
        drop_m  = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bcnt_m  = 0;
    drop_m  = 1'b0;
    pkt_m   = 16'd0;
    trunc_m = 16'd0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    pushes_m = 0;
  endtask

  // One clock cycle: drive at negedge, check everything 1 time unit later.
  task automatic cycle(input logic v, input logic [LS-1:0] d, input logic l,
                       input logic f, output logic acc);
    logic [LS:0] head;
    logic        exp_rdy;
    logic        exp_wr;
    logic        exp_busy;
    logic [LS:0] exp_wd;
    @(negedge clk);
    tvalid = v; tdata = d; tlast = l; wfull = f;
    #1;
    cyc++;
    exp_rdy  = drop_m || (exp_q.size() < 2);
    exp_wr   = (exp_q.size() != 0) && !f;
    exp_busy = (exp_q.size() != 0) || (bcnt_m != 0) || drop_m;
    exp_wd   = (exp_q.size() != 0) ? exp_q[0] : {(LS+1){1'b0}};
    total++; if (tready !== exp_rdy) begin bad++; $display("FAIL tready cyc=%0d got=%b want=%b", cyc, tready, exp_rdy); end
    total++; if (wr !== exp_wr) begin bad++; $display("FAIL o_wr cyc=%0d got=%b want=%b full=%b", cyc, wr, exp_wr, f); end
    total++; if (wdata !== exp_wd) begin bad++; $display("FAIL o_wdata cyc=%0d got=%h want=%h", cyc, wdata, exp_wd); end
    total++; if (busy !== exp_busy) begin bad++; $display("FAIL o_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy); end
    total++; if (pkt_cnt !== pkt_m) begin bad++; $display("FAIL pkt_count cyc=%0d got=%h want=%h", cyc, pkt_cnt, pkt_m); end
    total++; if (trunc_cnt !== trunc_m) begin bad++; $display("FAIL trunc_count cyc=%0d got=%h want=%h", cyc, trunc_cnt, trunc_m); end
    if (wr === 1'b1) begin
      obs_q.push_back(wdata);
      obs_cyc.push_back(cyc);
      if (exp_q.size() != 0) begin
        head = exp_q.pop_front();
        if (head[LS]) pkt_m = pkt_m + 16'd1;
      end
    end
    acc = v && (tready === 1'b1);
    if (acc) model_accept(d, l);
  endtask

  task automatic send_beat(input logic [LS-1:0] d, input logic l, input logic f);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, d, l, f, acc);
      n++;
    end
    total++;
    if (!acc) begin bad++; $display("FAIL send_beat timeout data=%h", d); end
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cycle(1'b0, '0, 1'b0, 1'b0, acc);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain timeout left=%0d want=0", exp_q.size()); end
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic finish_pkt();
    send_beat(8'hEE, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_reset();
    tvalid = 1'b1; tdata = 8'h5A; tlast = 1'b0; wfull = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", tready); end
    total++; if (wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b want=0", wr); end
    total++; if (wdata !== 9'h000) begin bad++; $display("FAIL rst_wdata got=%h want=000", wdata); end
    total++; if (pkt_cnt !== 16'h0000 || trunc_cnt !== 16'h0000) begin bad++; $display("FAIL rst_counts got=%h/%h want=0/0", pkt_cnt, trunc_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL rst_release_tready got=%b want=0", tready); end
    model_reset();
  endtask

  task automatic test_basic();
    clear_obs();
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b1, 1'b0);
    drain();
    total++; if (obs_q.size() != 3) begin bad++; $display("FAIL basic_nwrites got=%0d want=3", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'h011 || obs_q[1] !== 9'h022 || obs_q[2] !== 9'h133) begin bad++; $display("FAIL basic_words got=%h,%h,%h want=011,022,133", obs_q[0], obs_q[1], obs_q[2]); end
      total++; if (obs_cyc[1] != obs_cyc[0] + 1 || obs_cyc[2] != obs_cyc[0] + 2) begin bad++; $display("FAIL basic_consecutive got=%0d,%0d,%0d want=consecutive", obs_cyc[0], obs_cyc[1], obs_cyc[2]); end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL basic_pkt got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_truncate();
    logic [15:0] p0;
    logic [15:0] t0;
    logic [LS-1:0] d;
    p0 = pkt_cnt; t0 = trunc_cnt;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      d = 8'hA0 + 8'(i);
      send_beat(d, (i == 5), 1'b0);
    end
    drain();
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL trunc_nwrites got=%0d want=4", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'h0A0 || obs_q[1] !== 9'h0A1 || obs_q[2] !== 9'h0A2 || obs_q[3] !== 9'h1A3) begin bad++; $display("FAIL trunc_words got=%h,%h,%h,%h want=0A0,0A1,0A2,1A3", obs_q[0], obs_q[1], obs_q[2], obs_q[3]); end
    end
    total++; if (trunc_cnt - t0 !== 16'd1) begin bad++; $display("FAIL trunc_count_delta got=%0d want=1", trunc_cnt - t0); end
    total++; if (pkt_cnt - p0 !== 16'd1) begin bad++; $display("FAIL trunc_pkt_delta got=%0d want=1", pkt_cnt - p0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL trunc_back_to_pass got=%b want=0", busy); end
  endtask

  task automatic test_full_hold();
    logic [LS-1:0] d;
    logic acc;
    int acc_hold;
    int acc_rel;
    clear_obs();
    d = 8'h40; acc_hold = 0; acc_rel = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, d, (d[1:0] == 2'b11), 1'b1, acc);
      if (acc) begin acc_hold++; d = d + 8'd1; end
    end
    total++; if (acc_hold != 2) begin bad++; $display("FAIL full_accepts got=%0d want=2", acc_hold); end
    total++; if (tready !== 1'b0) begin bad++; $display("FAIL full_tready got=%b want=0", tready); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, d, (d[1:0] == 2'b11), 1'b0, acc);
      if (acc) begin acc_rel++; d = d + 8'd1; end
    end
    total++; if (acc_rel != 5) begin bad++; $display("FAIL full_resume_rate got=%0d want=5", acc_rel); end
    total++; if (obs_q.size() != 6) begin bad++; $display("FAIL full_nwrites got=%0d want=6", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'h040 || obs_q[1] !== 9'h041) begin bad++; $display("FAIL full_order got=%h,%h want=040,041", obs_q[0], obs_q[1]); end
    end
    finish_pkt();
  endtask

  task automatic test_toggle_full();
    logic acc;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), ($urandom_range(0, 2) == 0), ((i % 2) == 1), acc);
    end
    finish_pkt();
    total++; if (obs_q.size() != pushes_m) begin bad++; $display("FAIL toggle_count got=%0d want=%0d", obs_q.size(), pushes_m); end
  endtask

  task automatic test_random();
    logic acc;
    clear_obs();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), acc);
    end
    finish_pkt();
    total++; if (obs_q.size() != pushes_m) begin bad++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), pushes_m); end
  endtask

  task automatic test_reset_mid();
    drain();
    send_beat(8'h61, 1'b0, 1'b1);
    send_beat(8'h62, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    wfull = 1'b0; tvalid = 1'b0;
    #1;
    total++; if (tready !== 1'b0 || wr !== 1'b0 || wdata !== 9'h000) begin bad++; $display("FAIL midrst_outputs got=%b/%b/%h want=0/0/000", tready, wr, wdata); end
    total++; if (busy !== 1'b0 || pkt_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin bad++; $display("FAIL midrst_state got=%b/%h/%h want=0/0/0", busy, pkt_cnt, trunc_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    send_beat(8'h55, 1'b1, 1'b0);
    drain();
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL midrst_nwrites got=%0d want=1", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'h155) begin bad++; $display("FAIL midrst_word got=%h want=155", obs_q[0]); end
    end
    total++; if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL midrst_pkt got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 65534; i++) begin
      send_beat(8'(i), 1'b1, 1'b0);
    end
    drain();
    total++; if (pkt_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=FFFF", pkt_cnt); end
    send_beat(8'h77, 1'b1, 1'b0);
    drain();
    total++; if (pkt_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_rollover got=%h want=0000", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_full_hold();
    test_toggle_full();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_fifo_writer.md
AXIS_FIFO_WRITER -- requirements
Module: axis_fifo_writer

Interface
REQ-001 Parameter LOGIC_SIZE, default 8, payload data width in bits.
REQ-002 Parameter MAX_PKT_LEN, default 256, maximum beats per packet written to the FIFO; legal range 2..65535.
REQ-003 i_wclk  input  1  write-domain clock; all logic is rising-edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_tdata  input  LOGIC_SIZE  AXI-Stream payload.
REQ-006 s_axis_tvalid  input  1  AXI-Stream valid.
REQ-007 s_axis_tlast  input  1  AXI-Stream end-of-packet.
REQ-008 s_axis_tready  output  1  AXI-Stream ready; registered, no combinational path from any input.
REQ-009 o_wr  output  1  write request to the async FIFO write port.
REQ-010 o_wdata  output  LOGIC_SIZE+1  FIFO word: bit LOGIC_SIZE = last flag, bits LOGIC_SIZE-1:0 = data.
REQ-011 i_wfull  input  1  FIFO full flag, write domain.
REQ-012 o_pkt_count  output  16  packets written to the FIFO, modulo 2^16.
REQ-013 o_trunc_count  output  16  packets truncated, modulo 2^16.
REQ-014 o_busy  output  1  high while a packet is partially written or buffered.

Function
REQ-015 Beat accepted on a rising edge iff s_axis_tvalid && s_axis_tready.
REQ-016 Internal 2-entry skid buffer, FIFO order; occupancy cnt in 0..2.
REQ-017 State PASS: s_axis_tready = (cnt < 2) from registered state; accepted beat pushed to the buffer.
REQ-018 o_wr = (cnt != 0) && !i_wfull, combinational; o_wdata = buffer head whenever cnt != 0, else 0.
REQ-019 Head popped on every edge where o_wr = 1; simultaneous push and pop leaves cnt unchanged and preserves order.
REQ-020 Minimum latency: beat accepted at edge N drives o_wr in the cycle after edge N (i_wfull low).
REQ-021 Beat counter bcnt (16 bits) counts beats pushed in the current packet; cleared after any pushed beat carrying last = 1.
REQ-022 Pushed last flag = s_axis_tlast || (bcnt == MAX_PKT_LEN-1).
REQ-023 If the last flag is forced (bcnt == MAX_PKT_LEN-1, s_axis_tlast = 0): o_trunc_count += 1, next state DROP.
REQ-024 State DROP: s_axis_tready = 1; accepted beats are discarded; an accepted beat with s_axis_tlast = 1 returns the block to PASS; nothing is pushed in DROP.
REQ-025 o_pkt_count increments on each edge where o_wr = 1 and o_wdata[LOGIC_SIZE] = 1.
REQ-026 i_wfull held high: o_wr = 0; buffer fills to 2; s_axis_tready then 0 in PASS; no data lost or duplicated.
REQ-027 o_busy = (cnt != 0) || (bcnt != 0) || (state == DROP).
REQ-028 Counters wrap from 0xFFFF to 0x0000 and never saturate.

Reset
REQ-029 While i_rst_n = 0: s_axis_tready = 0, o_wr = 0, o_wdata = 0, cnt = 0, bcnt = 0, state PASS, both counters 0, o_busy = 0.
REQ-030 s_axis_tready rises at the first i_wclk edge after i_rst_n deasserts.
REQ-031 Reset asserted mid-packet discards buffered beats and partial-packet state immediately, with no further o_wr pulse.

Verification
REQ-032 LOGIC_SIZE=8, MAX_PKT_LEN=4, i_wfull=0: send 3 beats 0x11,0x22,0x33 with tlast on 0x33 -> o_wdata 0x011,0x022,0x133 on consecutive cycles; o_pkt_count = 1.
REQ-033 Send 6 beats 0xA0..0xA5 with tlast on 0xA5 -> FIFO receives 0x0A0,0x0A1,0x0A2,0x1A3; 0xA4 and 0xA5 are dropped; o_trunc_count = 1; o_pkt_count = 1; state returns to PASS.
REQ-034 Hold i_wfull=1 and stream tvalid=1 -> s_axis_tready falls after 2 accepts; release i_wfull -> both buffered beats are written in order, then streaming resumes at 1 beat/cycle.
REQ-035 Continuous tvalid=1 with i_wfull toggling every cycle -> output sequence equals input sequence exactly; at no edge are both o_wr=1 and i_wfull=1.
REQ-036 Assert i_rst_n=0 after 2 beats of a packet -> all outputs 0 immediately; after release, a 1-beat packet 0x55 with tlast -> single write 0x155; o_pkt_count = 1.
REQ-037 Preload o_pkt_count to 0xFFFF by sending 65535 1-beat packets, then send one more -> o_pkt_count = 0x0000.
